// File: rtl/elevator_ctrl.sv
// elevator_ctrl: four-floor elevator car controller.
// Latches floor requests, schedules motion by SCAN, and times both floor
// travel and door dwell using a free-running tick prescaler. The floor code,
// direction flags and door flag feed the display path. The pending lamps show
// outstanding requests.
// Optional feature: define ELEV_OBSTRUCT_EN to add the obstruct input. While
// obstruct is high with the door open, the door is held open.
module elevator_ctrl #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned TRAVEL_TICKS = 8,
  parameter int unsigned DOOR_TICKS   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
`ifdef ELEV_OBSTRUCT_EN
  input  logic       obstruct,
`endif
  output logic [1:0] floor,
  output logic       up,
  output logic       down,
  output logic       door,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_e;

  // Outcome of the scheduling decision taken at a floor.
  typedef struct packed {
    state_e     state;
    logic       dir_up;
    logic [3:0] clear;
  } decision_t;

  localparam int unsigned PRE_W   = $clog2(TICK_DIV);
  localparam int unsigned TMR_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_TICKS - 1);
  localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_TICKS - 1);

  state_e           state_q, state_d;
  logic [1:0]       floor_q, floor_d;
  logic             dir_q, dir_d;        // 1 = up, 0 = down
  logic [3:0]       pending_q, pending_d;
  logic [TMR_W-1:0] timer_q, timer_d;    // travel or door timer, one at a time
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             up_q, down_q, door_q;

  logic             tick;
  logic             door_hold;
  logic [3:0]       here;
  logic [1:0]       floor_step;
  logic [3:0]       clear;
  logic [3:0]       latch_mask;
  decision_t        dec;

`ifdef ELEV_OBSTRUCT_EN
  assign door_hold = obstruct;
`else
  assign door_hold = 1'b0;
`endif

  assign tick       = (pre_q == PRE_LAST);
  assign pre_d      = tick ? '0 : pre_q + PRE_W'(1);
  assign here       = 4'b0001 << floor_q;
  assign floor_step = (state_q == S_MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;

  // SCAN decision: serve this floor, then keep going the same way while
  // requests remain ahead, otherwise turn around, otherwise go idle.
  function automatic decision_t decide(input logic [1:0] f, input logic dir_up,
                                       input logic [3:0] pend, input logic skip_here);
    logic [3:0] at_f;
    logic [3:0] above;
    logic [3:0] below;
    decision_t  d;
    at_f     = 4'b0001 << f;
    above    = pend & ~({at_f[2:0], 1'b0} - 4'd1);
    below    = pend & (at_f - 4'd1);
    d.state  = S_IDLE;
    d.dir_up = dir_up;
    d.clear  = 4'b0000;
    if (!skip_here && ((pend & at_f) != 4'b0000)) begin
      d.state = S_DOOR_OPEN;
      d.clear = at_f;
    end else if (dir_up && (above != 4'b0000)) begin
      d.state = S_MOVE_UP;
    end else if (!dir_up && (below != 4'b0000)) begin
      d.state = S_MOVE_DOWN;
    end else if (dir_up && (below != 4'b0000)) begin
      d.state  = S_MOVE_DOWN;
      d.dir_up = 1'b0;
    end else if (!dir_up && (above != 4'b0000)) begin
      d.state  = S_MOVE_UP;
      d.dir_up = 1'b1;
    end
    return d;
  endfunction

  // Next-state logic: car state, floor, direction, timer and request latch.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    clear      = 4'b0000;
    latch_mask = 4'b0000;
    dec        = '{S_IDLE, dir_q, 4'b0000};
    unique case (state_q)
      S_IDLE: begin
        dec     = decide(floor_q, dir_q, pending_q, 1'b0);
        state_d = dec.state;
        dir_d   = dec.dir_up;
        clear   = dec.clear;
        timer_d = '0;
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (tick) begin
          if (timer_q == TRAVEL_LAST) begin
            // Arrival and the decision at the new floor share one edge.
            floor_d = floor_step;
            dec     = decide(floor_step, dir_q, pending_q, 1'b0);
            state_d = dec.state;
            dir_d   = dec.dir_up;
            clear   = dec.clear;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      S_DOOR_OPEN: begin
        // A press at the open floor extends the dwell instead of latching.
        latch_mask = here;
        if (door_hold || ((req & here) != 4'b0000)) begin
          timer_d = '0;
        end else if (tick) begin
          if (timer_q == DOOR_LAST) begin
            dec     = decide(floor_q, dir_q, pending_q, 1'b1);
            state_d = dec.state;
            dir_d   = dec.dir_up;
            clear   = dec.clear;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = (pending_q | (req & ~latch_mask)) & ~clear;
  end

  // Tick prescaler, free-running from reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of statement order.
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Car state registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      floor_q   <= 2'd0;
      dir_q     <= 1'b1;
      pending_q <= 4'b0000;
      timer_q   <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      up_q      <= (state_d == S_MOVE_UP);
      down_q    <= (state_d == S_MOVE_DOWN);
      door_q    <= (state_d == S_DOOR_OPEN);
    end
  end

  assign floor   = floor_q;
  assign up      = up_q;
  assign down    = down_q;
  assign door    = door_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed testbench for elevator_ctrl (TICK_DIV=2, TRAVEL_TICKS=3, DOOR_TICKS=4).
// Expected stops (floor, pending lamps at arrival) are queued when a request is
// driven and compared when the door opens. Build with ELEV_OBSTRUCT_EN defined
// to exercise the obstruct input.
module tb_elevator_ctrl;

  localparam int TD = 2;
  localparam int TT = 3;
  localparam int DT = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [1:0] floor;
  logic       up, down, door;
  logic [3:0] pending;
`ifdef ELEV_OBSTRUCT_EN
  logic       obstruct = 1'b0;
`endif

  typedef struct {
    logic [1:0] floor;
    logic [3:0] pend;
  } stop_t;

  stop_t sb[$];
  stop_t st;
  int    total     = 0;
  int    bad       = 0;
  logic  door_prev = 1'b0;
  logic  seen_down = 1'b0;
  int    n;

  always #5 clk = ~clk;

  elevator_ctrl #(
    .TICK_DIV    (TD),
    .TRAVEL_TICKS(TT),
    .DOOR_TICKS  (DT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
`ifdef ELEV_OBSTRUCT_EN
    .obstruct(obstruct),
`endif
    .floor  (floor),
    .up     (up),
    .down   (down),
    .door   (door),
    .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] sig(input int sel);
    case (sel)
      0:       return {3'b000, door};
      1:       return {3'b000, up};
      2:       return {3'b000, down};
      default: return {2'b00, floor};
    endcase
  endfunction

  // Waits (bounded) for an output to take a value; returns cycles waited.
  task automatic wait_sig(input int sel, input logic [3:0] val, input int budget,
                          input string tag, output int cycles);
    cycles = 0;
    while (sig(sel) !== val && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_reached"}, sig(sel), val);
  endtask

  // Per-cycle monitor: direction/door exclusivity and scoreboard stops.
  always begin
    @(posedge clk);
    #1;
    check("excl", $onehot0({up, down, door}), 1'b1);
    if (down) seen_down = 1'b1;
    if (door && !door_prev) begin
      check("stop_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        st = sb.pop_front();
        check("stop_floor", floor, st.floor);
        check("stop_pending", pending, st.pend);
      end
    end
    door_prev = door;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and quiet idle.
    step(3);
    check("reset_state", {floor, up, down, door, pending}, 0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("idle100", {floor, up, down, door, pending}, 0);
    end

    // Single request to the top floor.
    req = 4'b1000;
    sb.push_back('{2'd3, 4'b0000});
    step(1);
    req = 4'b0000;
    check("s2_pend_latched", pending, 4'b1000);
    check("s2_up_not_yet", up, 1'b0);
    step(1);
    check("s2_up", up, 1'b1);
    wait_sig(3, 4'd1, 10, "s2_f1", n);
    check("s2_f1_time", (n >= 5 && n <= 6), 1'b1);
    wait_sig(3, 4'd2, 10, "s2_f2", n);
    check("s2_f2_time", n, 6);
    wait_sig(3, 4'd3, 10, "s2_f3", n);
    check("s2_f3_time", n, 6);
    check("s2_door_on_arrival", door, 1'b1);
    check("s2_up_off", up, 1'b0);
    check("s2_pend_clear", pending, 4'b0000);
    wait_sig(0, 4'd0, 20, "s2_door_close", n);
    check("s2_door_time", n, 8);
    step(3);
    check("s2_idle", {floor, up, down, door, pending}, {2'd3, 7'd0});

    // Return to floor 0.
    req = 4'b0001;
    sb.push_back('{2'd0, 4'b0000});
    step(1);
    req = 4'b0000;
    wait_sig(0, 4'd1, 40, "s3_prep_door", n);
    check("s3_prep_floor", floor, 2'd0);
    wait_sig(0, 4'd0, 20, "s3_prep_close", n);

    // Mid-travel request at floor 1 causes an intermediate stop.
    seen_down = 1'b0;
    req = 4'b0100;
    sb.push_back('{2'd1, 4'b0100});
    sb.push_back('{2'd2, 4'b0000});
    step(1);
    req = 4'b0000;
    step(1);
    check("s3_up", up, 1'b1);
    step(2);
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    check("s3_pend_both", pending, 4'b0110);
    wait_sig(3, 4'd1, 10, "s3_f1", n);
    check("s3_f1_door", door, 1'b1);
    wait_sig(0, 4'd0, 20, "s3_f1_close", n);
    check("s3_f1_door_time", n, 8);
    wait_sig(3, 4'd2, 10, "s3_f2", n);
    check("s3_f2_time", n, 6);
    check("s3_f2_door", door, 1'b1);
    wait_sig(0, 4'd0, 20, "s3_f2_close", n);
    check("s3_no_down", seen_down, 1'b0);

    // Requests above and below from floor 2 heading up: up first.
    req = 4'b1001;
    sb.push_back('{2'd3, 4'b0001});
    sb.push_back('{2'd0, 4'b0000});
    step(1);
    req = 4'b0000;
    check("s4_pend", pending, 4'b1001);
    step(1);
    check("s4_up_first", {up, down}, 2'b10);
    wait_sig(3, 4'd3, 10, "s4_f3", n);
    check("s4_f3_door", door, 1'b1);
    wait_sig(0, 4'd0, 20, "s4_f3_close", n);
    check("s4_reverse", down, 1'b1);
    wait_sig(3, 4'd0, 30, "s4_f0", n);
    check("s4_f0_door", door, 1'b1);
    wait_sig(0, 4'd0, 20, "s4_f0_close", n);

    // Asynchronous reset while travelling between floors.
    req = 4'b1000;
    step(1);
    req = 4'b0000;
    step(2);
    check("s5_up", up, 1'b1);
    step(3);
    check("s5_between", {floor, up}, {2'd0, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    check("s5_async_reset", {floor, up, down, door, pending}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("s5_after_release", {floor, up, down, door, pending}, 0);
    end

    // Door dwell, with obstruct held when the feature is built in.
    req = 4'b0001;
    sb.push_back('{2'd0, 4'b0000});
    step(1);
    req = 4'b0000;
    check("s6_pend", pending, 4'b0001);
    check("s6_door_not_yet", door, 1'b0);
    step(1);
    check("s6_door_2nd_clk", door, 1'b1);
`ifdef ELEV_OBSTRUCT_EN
    obstruct = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      check("s6_obstruct_hold", door, 1'b1);
    end
    obstruct = 1'b0;
`endif
    wait_sig(0, 4'd0, 20, "s6_close", n);
    check("s6_close_time", (n >= 7 && n <= 8), 1'b1);

    // Current-floor press while open restarts the dwell without latching.
    req = 4'b0001;
    sb.push_back('{2'd0, 4'b0000});
    step(1);
    req = 4'b0000;
    step(1);
    check("s7_door", door, 1'b1);
    step(4);
    req = 4'b0001;
    step(1);
    req = 4'b0000;
    check("s7_not_latched", pending, 4'b0000);
    check("s7_still_open", door, 1'b1);
    wait_sig(0, 4'd0, 20, "s7_close", n);
    check("s7_close_time", (n >= 7 && n <= 8), 1'b1);

    step(2);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Four-floor elevator car controller that drives the existing display path.
- Latches floor requests and schedules car motion by SCAN (keeps current direction while requests remain ahead).
- Times travel between floors and door-open dwell.
- Outputs floor code, UP/DOWN and door flag (P) consumed by Display; pending-request lamps for the panel.

Parameters:
- TICK_DIV, 1000: clk cycles per timing tick (internal prescaler), >=2.
- TRAVEL_TICKS, 8: ticks to travel one floor, >=1.
- DOOR_TICKS, 6: ticks door stays open, >=1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  4  floor request buttons, level, bit i = floor i
- floor  out  2  current floor, 0..3 (floor[1] -> A_1, floor[0] -> B_1)
- up  out  1  car moving up
- down  out  1  car moving down
- door  out  1  door open (drives P)
- pending  out  4  latched outstanding requests

Behaviour:
- Reset (reset=0, async): state IDLE, floor=0, up=down=door=0, pending=0, dir=UP, prescaler/timers=0. Reset mid-travel or door-open aborts immediately; car reports floor 0.
- Prescaler: counts 0..TICK_DIV-1, tick=1 for one clk when it wraps. Free-running from reset.
- Request latch: pending <= pending | req each clk (1-cycle latency). Exception: req bit of current floor while state is DOOR_OPEN is not latched; it restarts door timer.
- Decision function D (from floor f, direction dir):
  - pending[f] -> DOOR_OPEN, clear pending[f].
  - else requests ahead in dir -> MOVE in dir.
  - else requests behind -> reverse dir, MOVE.
  - else IDLE.
- IDLE: evaluate D every clk. A request at the current floor opens the door on the 2nd clk after req asserts.
- MOVE_UP / MOVE_DOWN:
  - up=1 (MOVE_UP) or down=1 (MOVE_DOWN); door=0.
  - Travel timer increments on tick.
  - On tick with timer==TRAVEL_TICKS-1: floor +/-1, timer=0, and D evaluated on the new floor in the same clk edge (arrival and door open are registered together).
  - floor never passes 3 or 0: MOVE_UP only entered when requests exist above.
  - Requests arriving mid-travel for a floor ahead cause a stop there.
- DOOR_OPEN:
  - door=1, up=down=0.
  - Door timer increments on tick; restarts to 0 on current-floor req.
  - On tick with timer==DOOR_TICKS-1: timer=0, evaluate D with pending[f] ignored.
- Simultaneous above and below requests in IDLE: dir register breaks the tie (last direction, UP after reset).
- All outputs registered; up, down, door mutually exclusive.

Optional Feature:
- Macro ELEV_OBSTRUCT_EN.
- Defined:
  - Extra input obstruct (1 bit). While obstruct=1 in DOOR_OPEN, door timer held at 0 and door stays open.
  - obstruct ignored in other states.
- Undefined: no obstruct port; door closes strictly after DOOR_TICKS ticks (plus restarts from current-floor req).

Test Plan (TICK_DIV=2, TRAVEL_TICKS=3, DOOR_TICKS=4):
- Reset release, req=0 for 100 clk -> floor=0, up=down=door=0, pending=0 throughout.
- req=4'b1000 pulse 1 clk from IDLE at floor 0:
  - pending=4'b1000 next clk; up=1.
  - floor steps 1,2,3 every 6 clk.
  - door=1 and pending=0 on the arrival edge at floor 3.
  - door=0 after 8 clk; state IDLE.
- At floor 0, req=4'b0100, then req bit 1 asserted during first travel -> car stops at floor 1 (door 8 clk), continues to 2; down never asserts.
- Car at floor 2 idle with dir=UP; req=4'b1001 same clk -> moves up to 3 first, then down to 0; pending clears 3 then 0.
- Assert reset=0 while up=1 between floors -> all outputs and pending 0 immediately (asynchronously, without a clk edge); after release, floor=0, IDLE.
- ELEV_OBSTRUCT_EN defined: obstruct=1 for 40 clk during DOOR_OPEN -> door stays 1, then closes 8 clk after obstruct drops. Undefined build: same stimulus without obstruct port, door closes after 8 clk.
